// File: rtl/hazard_scoreboard.sv
// Per-register in-flight scoreboard for the in-order pipeline: decides D->X issue
// and registers the X-stage operand forwarding selects.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned WB_STAGE  = 3,
  parameter int unsigned STG_W     = 2,
  parameter bit          RF_BYPASS = 1'b0,
  parameter int unsigned PERF_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  input  logic [ADDR_W-1:0]   issue_rd_i,
  input  logic                issue_rd_wr_i,
  input  logic [STG_W-1:0]    issue_lat_i,
  input  logic [ADDR_W-1:0]   rs1_addr_i,
  input  logic [ADDR_W-1:0]   rs2_addr_i,
  input  logic                rs1_used_i,
  input  logic                rs2_used_i,
  input  logic                flush_i,
  input  logic                hold_i,
  output logic                stall_o,
  output logic [STG_W-1:0]    fwd_rs1_x_o,
  output logic [STG_W-1:0]    fwd_rs2_x_o,
  output logic [NUM_REGS-1:0] busy_vec_o,
  output logic [PERF_W-1:0]   stall_cycles_o
);

  localparam logic [STG_W-1:0] WB  = STG_W'(WB_STAGE);
  localparam logic [STG_W-1:0] ONE = STG_W'(1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [STG_W-1:0]    age_q [NUM_REGS];
  logic [STG_W-1:0]    age_d [NUM_REGS];
  logic [STG_W-1:0]    lat_q [NUM_REGS];
  logic [STG_W-1:0]    lat_d [NUM_REGS];
  logic [STG_W-1:0]    fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [PERF_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]   src_addr [2];
  logic [1:0]          src_used;
  logic [1:0]          haz;
  logic [STG_W-1:0]    sel [2];
  logic [STG_W-1:0]    lat_clamp;
  logic                issue;
  logic                alloc;

  assign src_addr[0] = rs1_addr_i;
  assign src_addr[1] = rs2_addr_i;
  assign src_used    = {rs2_used_i, rs1_used_i};

  // Source lookup: only the youngest producer is ever tracked per register.
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      haz[s] = 1'b0;
      sel[s] = '0;
      if (src_used[s] && (src_addr[s] != '0) && (32'(src_addr[s]) < NUM_REGS)
          && busy_q[src_addr[s]]) begin
        if (age_q[src_addr[s]] < lat_q[src_addr[s]]) begin
          haz[s] = 1'b1;
        end else if (age_q[src_addr[s]] == WB) begin
          haz[s] = !RF_BYPASS;
        end else begin
          sel[s] = age_q[src_addr[s]] + ONE;
        end
      end
    end
  end

  always_comb begin
    if (issue_lat_i == '0) begin
      lat_clamp = ONE;
    end else if (issue_lat_i > WB) begin
      lat_clamp = WB;
    end else begin
      lat_clamp = issue_lat_i;
    end
  end

  assign stall_o = rst_ni & issue_valid_i & (|haz) & ~flush_i;
  assign issue   = issue_valid_i & ~stall_o & ~hold_i & ~flush_i;
  assign alloc   = issue & issue_rd_wr_i & (issue_rd_i != '0)
                   & (32'(issue_rd_i) < NUM_REGS);

  // Aging runs first so a same-cycle allocation overrides a retire of that rd.
  always_comb begin
    busy_d = busy_q;
    age_d  = age_q;
    lat_d  = lat_q;
    fwd1_d = fwd1_q;
    fwd2_d = fwd2_q;
    cnt_d  = cnt_q;
    if (!hold_i) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (busy_q[r]) begin
          if (age_q[r] == WB) begin
            busy_d[r] = 1'b0;
            age_d[r]  = '0;
            lat_d[r]  = '0;
          end else begin
            age_d[r] = age_q[r] + ONE;
          end
        end
      end
      if (alloc) begin
        busy_d[issue_rd_i] = 1'b1;
        age_d[issue_rd_i]  = ONE;
        lat_d[issue_rd_i]  = lat_clamp;
      end
      fwd1_d = issue ? sel[0] : '0;
      fwd2_d = issue ? sel[1] : '0;
      if (stall_o && (cnt_q != '1)) begin
        cnt_d = cnt_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
      age_q  <= '{default: '0};
      lat_q  <= '{default: '0};
      fwd1_q <= '0;
      fwd2_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      age_q  <= age_d;
      lat_q  <= lat_d;
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fwd_rs1_x_o    = fwd1_q;
  assign fwd_rs2_x_o    = fwd2_q;
  assign busy_vec_o     = busy_q;
  assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (non-bypassing RF with 32-bit counter,
// write-through RF with 4-bit counter) checked against an in-flight pipeline model.
module tb_hazard_scoreboard;

  localparam int WB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, v, wr, u1, u2, fl, hd;
  logic [4:0] rd, a1, a2;
  logic [1:0] lat;

  logic        stall_w [2];
  logic [1:0]  f1_w [2];
  logic [1:0]  f2_w [2];
  logic [31:0] busy_w [2];
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  hazard_scoreboard #(.RF_BYPASS(1'b0), .PERF_W(32)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(v), .issue_rd_i(rd),
    .issue_rd_wr_i(wr), .issue_lat_i(lat), .rs1_addr_i(a1), .rs2_addr_i(a2),
    .rs1_used_i(u1), .rs2_used_i(u2), .flush_i(fl), .hold_i(hd),
    .stall_o(stall_w[0]), .fwd_rs1_x_o(f1_w[0]), .fwd_rs2_x_o(f2_w[0]),
    .busy_vec_o(busy_w[0]), .stall_cycles_o(cnt0));

  hazard_scoreboard #(.RF_BYPASS(1'b1), .PERF_W(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(v), .issue_rd_i(rd),
    .issue_rd_wr_i(wr), .issue_lat_i(lat), .rs1_addr_i(a1), .rs2_addr_i(a2),
    .rs1_used_i(u1), .rs2_used_i(u2), .flush_i(fl), .hold_i(hd),
    .stall_o(stall_w[1]), .fwd_rs1_x_o(f1_w[1]), .fwd_rs2_x_o(f2_w[1]),
    .busy_vec_o(busy_w[1]), .stall_cycles_o(cnt1));

  // Model: instructions occupying pipeline stages X(1)..W(WB), per instance.
  bit              mv   [2][WB+1];
  int unsigned     mrd  [2][WB+1];
  int unsigned     mlat [2][WB+1];
  int unsigned     mf1 [2], mf2 [2];
  longint unsigned mcnt [2], mmax [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned clamp(input int unsigned l);
    if (l == 0) return 1;
    if (l > WB) return WB;
    return l;
  endfunction

  // Youngest producer in the pipeline decides the operand source.
  function automatic void lookup(input int b, input int unsigned addr, input bit used,
                                 output bit hz, output int unsigned s);
    hz = 1'b0;
    s  = 0;
    if (!used || addr == 0) return;
    for (int k = 1; k <= WB; k++) begin
      if (mv[b][k] && mrd[b][k] == addr) begin
        if (k < int'(mlat[b][k])) hz = 1'b1;
        else if (k == WB) hz = (b == 0);
        else s = k + 1;
        return;
      end
    end
  endfunction

  task automatic clear_model();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k <= WB; k++) begin
        mv[b][k] = 1'b0; mrd[b][k] = 0; mlat[b][k] = 0;
      end
      mf1[b] = 0; mf2[b] = 0; mcnt[b] = 0;
    end
  endtask

  task automatic set_in(input bit iv, input int unsigned ird, input bit iwr,
                        input int unsigned ilat, input int unsigned ia1, input bit iu1,
                        input int unsigned ia2, input bit iu2, input bit ifl, input bit ihd);
    v = iv; rd = 5'(ird); wr = iwr; lat = 2'(ilat);
    a1 = 5'(ia1); u1 = iu1; a2 = 5'(ia2); u2 = iu2; fl = ifl; hd = ihd;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step();
    bit hz1, hz2, st;
    int unsigned s1, s2;
    bit pst [2];
    bit piss [2];
    int unsigned ps1 [2], ps2 [2];
    logic [31:0] eb;
    #1;
    for (int b = 0; b < 2; b++) begin
      lookup(b, a1, u1, hz1, s1);
      lookup(b, a2, u2, hz2, s2);
      st = rst_n && v && (hz1 || hz2) && !fl;
      check_eq($sformatf("stall%0d", b), 64'(stall_w[b]), 64'(st));
      pst[b] = st; ps1[b] = s1; ps2[b] = s2;
      piss[b] = v && !st && !hd && !fl;
    end
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else if (!hd) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = WB; k >= 2; k--) begin
          mv[b][k] = mv[b][k-1]; mrd[b][k] = mrd[b][k-1]; mlat[b][k] = mlat[b][k-1];
        end
        mv[b][1]   = piss[b] && wr && (rd != 0);
        mrd[b][1]  = rd;
        mlat[b][1] = clamp(lat);
        mf1[b] = piss[b] ? ps1[b] : 0;
        mf2[b] = piss[b] ? ps2[b] : 0;
        if (pst[b] && mcnt[b] < mmax[b]) mcnt[b]++;
      end
    end
    #1;
    for (int b = 0; b < 2; b++) begin
      eb = '0;
      for (int k = 1; k <= WB; k++) if (mv[b][k]) eb[mrd[b][k]] = 1'b1;
      check_eq($sformatf("busy%0d", b), 64'(busy_w[b]), 64'(eb));
      check_eq($sformatf("fwd1_%0d", b), 64'(f1_w[b]), 64'(mf1[b]));
      check_eq($sformatf("fwd2_%0d", b), 64'(f2_w[b]), 64'(mf2[b]));
    end
    check_eq("cnt0", 64'(cnt0), mcnt[0]);
    check_eq("cnt1", 64'(cnt1), mcnt[1]);
    @(negedge clk);
  endtask

  initial begin
    mmax[0] = 64'hFFFF_FFFF;
    mmax[1] = 15;
    clear_model();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;

    // ALU -> dependent ALU
    set_in(1, 5, 1, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 6, 1, 1, 5, 1, 0, 0, 0, 0); #1 check_eq("alu_stall", 64'(stall_w[0]), 0);
    step();
    check_eq("alu_fwd", 64'(f1_w[0]), 2);

    // Load-use
    set_in(1, 7, 1, 2, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 8, 1, 1, 0, 0, 7, 1, 0, 0); #1 check_eq("lu_stall1", 64'(stall_w[0]), 1);
    step();
    #1 check_eq("lu_stall0", 64'(stall_w[0]), 0);
    step();
    check_eq("lu_fwd", 64'(f2_w[0]), 3);

    // WD distance
    set_in(1, 9, 1, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 10, 1, 1, 0, 0, 0, 0, 0, 0); step(); step();
    set_in(1, 11, 1, 1, 9, 1, 0, 0, 0, 0);
    #1 check_eq("wd_stall_nobyp", 64'(stall_w[0]), 1);
    check_eq("wd_stall_byp", 64'(stall_w[1]), 0);
    step(); step();
    check_eq("wd_fwd", 64'(f1_w[0]), 0);

    // Flush during hazard
    set_in(1, 12, 1, 2, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 13, 1, 1, 0, 0, 12, 1, 1, 0); #1 check_eq("fl_stall", 64'(stall_w[0]), 0);
    step();
    check_eq("fl_busy13", 64'(busy_w[0][13]), 0);

    // Hold and WAW
    set_in(1, 4, 1, 2, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step(); step(); step();
    check_eq("hold_busy4", 64'(busy_w[0][4]), 1);
    set_in(1, 4, 1, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 14, 1, 1, 4, 1, 0, 0, 0, 0); step();
    check_eq("waw_fwd", 64'(f1_w[0]), 2);

    // x0 never tracked, then reset with live entries
    set_in(1, 0, 1, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 15, 1, 2, 0, 0, 0, 0, 0, 0); step();
    rst_n = 1'b0; step();
    check_eq("rst_busy", 64'(busy_w[0]), 0);
    rst_n = 1'b1;

    // Randomized traffic on a small register window to provoke hazards
    repeat (3000) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
             $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1) != 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
